bp_cfg_loader: RTL and testbench

// - Runtime successor to static compile-time config selection: streams a selected config set
//   (addr/data word list) from a config ROM onto per-core config buses.
// - Sits between the host/boot controller and the num_core_p core config slaves.
// - Supports broadcast or per-core sequential load, core masking, early terminator and ready timeout.

---
 rtl/bp_cfg_loader.sv | 216 +++++++++++++++++++++
 tb/tb_bp_cfg_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_loader.sv
// Streams a selected config set (addr/data words) from a config ROM onto per-core config buses.
// Broadcast or per-core sequential load, core masking, all-ones address terminator, ready timeout.
module bp_cfg_loader #(
    parameter int unsigned num_core_p       = 4,
    parameter int unsigned max_cfgs_p       = 128,
    parameter int unsigned cfg_els_p        = 16,
    parameter int unsigned cfg_addr_width_p = 16,
    parameter int unsigned cfg_data_width_p = 64,
    parameter int unsigned timeout_p        = 1024
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_i,
    input  logic                                                 start_i,
    input  logic                                                 mode_i,
    input  logic [num_core_p-1:0]                                core_mask_i,
    input  logic [$clog2(max_cfgs_p)-1:0]                        cfg_sel_i,
    output logic                                                 rom_v_o,
    output logic [$clog2(max_cfgs_p)+$clog2(cfg_els_p)-1:0]      rom_addr_o,
    input  logic [cfg_addr_width_p+cfg_data_width_p-1:0]         rom_data_i,
    output logic [num_core_p-1:0]                                cfg_v_o,
    output logic [cfg_addr_width_p-1:0]                          cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                          cfg_data_o,
    input  logic [num_core_p-1:0]                                cfg_ready_i,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic                                                 err_o
);

    localparam int unsigned lg_max_cfgs_lp = $clog2(max_cfgs_p);
    localparam int unsigned lg_cfg_els_lp  = $clog2(cfg_els_p);
    localparam int unsigned lg_core_lp     = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int unsigned core_sel_w_lp  = lg_core_lp + 1;
    localparam int unsigned timer_w_lp     = $clog2(timeout_p + 1);
    localparam int unsigned rom_addr_w_lp  = lg_max_cfgs_lp + lg_cfg_els_lp;
    localparam int unsigned word_w_lp      = cfg_addr_width_p + cfg_data_width_p;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_ROM = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_e;

    state_e                      state_q, state_n;
    logic                        mode_q, mode_n;
    logic [num_core_p-1:0]       mask_q, mask_n;
    logic [lg_max_cfgs_lp-1:0]   sel_q, sel_n;
    logic [lg_cfg_els_lp-1:0]    word_idx_q, word_idx_n;
    logic [lg_core_lp-1:0]       core_idx_q, core_idx_n;
    logic [num_core_p-1:0]       acc_q, acc_n;
    logic [timer_w_lp-1:0]       timer_q, timer_n;
    logic                        term_q, term_n;
    logic [word_w_lp-1:0]        word_q, word_n;

    logic                        rom_v_q;
    logic [rom_addr_w_lp-1:0]    rom_addr_q;
    logic [num_core_p-1:0]       cfg_v_q, cfg_v_n;
    logic                        busy_q, done_q, err_q, done_n;

    logic [num_core_p-1:0]       accepts, acc_all;
    logic [timer_w_lp-1:0]       timer_inc;
    logic [core_sel_w_lp-1:0]    nxt_core, first_core;
    logic                        word_done, set_done;

    // Lowest set mask bit at index >= from; MSB of the result flags that one was found.
    function automatic logic [core_sel_w_lp-1:0] find_core(input logic [num_core_p-1:0] m,
                                                           input logic [core_sel_w_lp-1:0] from);
        logic [core_sel_w_lp-1:0] r;
        r = '0;
        for (int i = int'(num_core_p) - 1; i >= 0; i--) begin
            if (m[i] && (core_sel_w_lp'(i) >= from)) begin
                r = {1'b1, lg_core_lp'(i)};
            end
        end
        return r;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        mask_n     = mask_q;
        sel_n      = sel_q;
        word_idx_n = word_idx_q;
        core_idx_n = core_idx_q;
        acc_n      = acc_q;
        timer_n    = timer_q;
        term_n     = term_q;
        word_n     = word_q;
        done_n     = 1'b0;
        word_done  = 1'b0;
        set_done   = 1'b0;
        accepts    = cfg_v_q & cfg_ready_i;
        acc_all    = acc_q | accepts;
        timer_inc  = timer_q + timer_w_lp'(1);
        nxt_core   = find_core(mask_q, core_sel_w_lp'(core_idx_q) + core_sel_w_lp'(1));
        first_core = find_core(core_mask_i, '0);

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    mode_n     = mode_i;
                    mask_n     = core_mask_i;
                    sel_n      = cfg_sel_i;
                    word_idx_n = '0;
                    core_idx_n = first_core[lg_core_lp-1:0];
                    acc_n      = '0;
                    timer_n    = '0;
                    term_n     = 1'b0;
                    if (core_mask_i == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            FETCH: state_n = WAIT_ROM;
            WAIT_ROM: begin
                // A terminator word is never loaded, so its all-ones address never reaches the bus.
                term_n = (rom_data_i[word_w_lp-1 -: cfg_addr_width_p] == '1);
                if (!term_n) begin
                    word_n = rom_data_i;
                end
                acc_n   = '0;
                timer_n = '0;
                state_n = SEND;
            end
            SEND: begin
                if (term_q) begin
                    word_done = 1'b1;
                    set_done  = 1'b1;
                end else begin
                    timer_n   = (|accepts) ? '0 : timer_inc;
                    word_done = mode_q ? (|accepts) : (acc_all == mask_q);
                    acc_n     = word_done ? '0 : acc_all;
                    set_done  = word_done && (word_idx_q == lg_cfg_els_lp'(cfg_els_p - 1));
                    if (word_done && !set_done) begin
                        word_idx_n = word_idx_q + lg_cfg_els_lp'(1);
                        state_n    = FETCH;
                    end else if (!word_done && !(|accepts) &&
                                 (timer_inc == timer_w_lp'(timeout_p))) begin
                        state_n = ERROR;
                    end
                end
                if (set_done) begin
                    if (mode_q && nxt_core[lg_core_lp]) begin
                        core_idx_n = nxt_core[lg_core_lp-1:0];
                        word_idx_n = '0;
                        state_n    = FETCH;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        cfg_v_n = '0;
        if ((state_n == SEND) && !term_n) begin
            cfg_v_n = mode_n ? (num_core_p'(1) << core_idx_n) : (mask_n & ~acc_n);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            mask_q     <= '0;
            sel_q      <= '0;
            word_idx_q <= '0;
            core_idx_q <= '0;
            acc_q      <= '0;
            timer_q    <= '0;
            term_q     <= 1'b0;
            word_q     <= '0;
            rom_v_q    <= 1'b0;
            rom_addr_q <= '0;
            cfg_v_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            mode_q     <= mode_n;
            mask_q     <= mask_n;
            sel_q      <= sel_n;
            word_idx_q <= word_idx_n;
            core_idx_q <= core_idx_n;
            acc_q      <= acc_n;
            timer_q    <= timer_n;
            term_q     <= term_n;
            word_q     <= word_n;
            rom_v_q    <= (state_n == FETCH);
            rom_addr_q <= (state_n == FETCH) ? {sel_n, word_idx_n} : '0;
            cfg_v_q    <= cfg_v_n;
            busy_q     <= (state_n == FETCH) || (state_n == WAIT_ROM) || (state_n == SEND);
            done_q     <= done_n;
            err_q      <= (state_n == ERROR);
        end
    end

    assign rom_v_o    = rom_v_q;
    assign rom_addr_o = rom_addr_q;
    assign cfg_v_o    = cfg_v_q;
    assign cfg_addr_o = word_q[word_w_lp-1 -: cfg_addr_width_p];
    assign cfg_data_o = word_q[cfg_data_width_p-1:0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader: ROM model, transfer monitor and immediate-assertion checks.
module tb_bp_cfg_loader;

    logic        clk = 1'b0;
    logic        reset_i, start_i, mode_i;
    logic [3:0]  core_mask_i, cfg_ready_i, cfg_v_o;
    logic [6:0]  cfg_sel_i;
    logic        rom_v_o, busy_o, done_o, err_o;
    logic [10:0] rom_addr_o;
    logic [79:0] rom_data_i;
    logic [15:0] cfg_addr_o;
    logic [63:0] cfg_data_o;

    int n_chk = 0;
    int n_pass = 0;
    int n;

    logic       mon_clr = 1'b0;
    logic [6:0] cur_sel = '0;
    logic       cur_mode = 1'b0;
    int rom_reads, done_cnt, mon_err, order_err, bad_addr, last_core;
    int xfers[4];
    int vcyc[4];

    bp_cfg_loader #(.timeout_p(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .core_mask_i (core_mask_i),
        .cfg_sel_i   (cfg_sel_i),
        .rom_v_o     (rom_v_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .cfg_v_o     (cfg_v_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_data_o  (cfg_data_o),
        .cfg_ready_i (cfg_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // ROM contents: sel 5 holds a terminator at word 3.
    function automatic logic [79:0] rom_word(input logic [6:0] sel, input logic [3:0] w);
        if (sel == 7'd5 && w == 4'd3) return {16'hFFFF, 64'h0};
        return {5'b0, sel, w, 32'hC0DE0000 | 32'(sel), 28'h0, w};
    endfunction

    always @(posedge clk) rom_data_i <= rom_word(rom_addr_o[10:4], rom_addr_o[3:0]);

    // Transfer monitor: each core must receive the selected set's words in order.
    always @(negedge clk) begin
        if (mon_clr) begin
            rom_reads = 0; done_cnt = 0; mon_err = 0; order_err = 0; bad_addr = 0; last_core = 0;
            for (int c = 0; c < 4; c++) begin
                xfers[c] = 0;
                vcyc[c]  = 0;
            end
        end else begin
            if (rom_v_o) rom_reads++;
            if (done_o) done_cnt++;
            for (int c = 0; c < 4; c++) begin
                if (cfg_v_o[c]) begin
                    vcyc[c]++;
                    if (cfg_addr_o == 16'hFFFF) bad_addr++;
                    if (cfg_ready_i[c]) begin
                        if ({cfg_addr_o, cfg_data_o} !== rom_word(cur_sel, 4'(xfers[c]))) mon_err++;
                        if (cur_mode && c < last_core) order_err++;
                        last_core = c;
                        xfers[c]++;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done_o !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic kick(input logic m, input logic [3:0] mask, input logic [6:0] sel);
        mode_i = m; core_mask_i = mask; cfg_sel_i = sel;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; core_mask_i = '0; cfg_sel_i = '0;
        cfg_ready_i = '0;
        clear_mon();
        repeat (3) tick();
        chk("rst_busy", 80'(busy_o), 80'(0));
        chk("rst_done", 80'(done_o), 80'(0));
        chk("rst_err", 80'(err_o), 80'(0));
        chk("rst_rom_v", 80'(rom_v_o), 80'(0));
        chk("rst_cfg_v", 80'(cfg_v_o), 80'(0));
        reset_i = 1'b0;
        tick();

        // Broadcast, all ready: 16 words at 3 cycles each.
        clear_mon(); cur_sel = 7'd2; cur_mode = 1'b0; cfg_ready_i = 4'hF;
        kick(1'b0, 4'hF, 7'd2);
        chk("t1_rom_v", 80'(rom_v_o), 80'(1));
        chk("t1_rom_addr", 80'(rom_addr_o), 80'(11'h020));
        chk("t1_busy", 80'(busy_o), 80'(1));
        tick();
        chk("t1_wait_v", 80'(cfg_v_o), 80'(0));
        tick();
        chk("t1_send_v", 80'(cfg_v_o), 80'(4'hF));
        wait_done(n);
        chk("t1_latency", 80'(n + 2), 80'(48));
        tick();
        chk("t1_done_pulse", 80'(done_o), 80'(0));
        chk("t1_idle_busy", 80'(busy_o), 80'(0));
        chk("t1_done_cnt", 80'(done_cnt), 80'(1));
        for (int c = 0; c < 4; c++) chk($sformatf("t1_xfer%0d", c), 80'(xfers[c]), 80'(16));
        chk("t1_vcyc0", 80'(vcyc[0]), 80'(16));
        chk("t1_rom_reads", 80'(rom_reads), 80'(16));
        chk("t1_data", 80'(mon_err), 80'(0));

        // Broadcast with core 1 late on word 0; a start while busy is ignored.
        clear_mon(); cur_sel = 7'd3; cfg_ready_i = 4'b1101;
        kick(1'b0, 4'hF, 7'd3);
        tick();
        tick();
        chk("t2_v_all", 80'(cfg_v_o), 80'(4'hF));
        tick();
        chk("t2_v_core1", 80'(cfg_v_o), 80'(4'b0010));
        for (int k = 4; k <= 7; k++) begin
            if (k == 4) begin
                start_i = 1'b1; cfg_sel_i = 7'd9; core_mask_i = 4'b0001;
            end
            tick();
            start_i = 1'b0;
            chk($sformatf("t2_hold_v%0d", k), 80'(cfg_v_o), 80'(4'b0010));
            chk($sformatf("t2_no_fetch%0d", k), 80'(rom_v_o), 80'(0));
        end
        cfg_ready_i = 4'hF;
        tick();
        chk("t2_fetch1_v", 80'(rom_v_o), 80'(1));
        chk("t2_fetch1_addr", 80'(rom_addr_o), 80'(11'h031));
        chk("t2_fetch1_cfg_v", 80'(cfg_v_o), 80'(0));
        wait_done(n);
        chk("t2_done", 80'(done_o), 80'(1));
        tick();
        chk("t2_vcyc1", 80'(vcyc[1]), 80'(21));
        chk("t2_vcyc0", 80'(vcyc[0]), 80'(16));
        chk("t2_xfer1", 80'(xfers[1]), 80'(16));
        chk("t2_data", 80'(mon_err), 80'(0));

        // Per-core sequential over cores 1 and 3.
        clear_mon(); cur_sel = 7'd7; cur_mode = 1'b1; cfg_ready_i = 4'hF;
        kick(1'b1, 4'b1010, 7'd7);
        chk("t3_rom_addr", 80'(rom_addr_o), 80'(11'h070));
        tick();
        tick();
        chk("t3_first_v", 80'(cfg_v_o), 80'(4'b0010));
        wait_done(n);
        chk("t3_latency", 80'(n + 2), 80'(96));
        tick();
        chk("t3_rom_reads", 80'(rom_reads), 80'(32));
        chk("t3_xfer1", 80'(xfers[1]), 80'(16));
        chk("t3_xfer3", 80'(xfers[3]), 80'(16));
        chk("t3_vcyc0", 80'(vcyc[0]), 80'(0));
        chk("t3_vcyc2", 80'(vcyc[2]), 80'(0));
        chk("t3_order", 80'(order_err), 80'(0));
        chk("t3_data", 80'(mon_err), 80'(0));

        // Terminator at word 3 of set 5.
        clear_mon(); cur_sel = 7'd5; cur_mode = 1'b0;
        kick(1'b0, 4'hF, 7'd5);
        wait_done(n);
        chk("t4_latency", 80'(n), 80'(12));
        tick();
        for (int c = 0; c < 4; c++) chk($sformatf("t4_xfer%0d", c), 80'(xfers[c]), 80'(3));
        chk("t4_bad_addr", 80'(bad_addr), 80'(0));
        chk("t4_rom_reads", 80'(rom_reads), 80'(4));
        chk("t4_data", 80'(mon_err), 80'(0));

        // Core 2 never ready: error 8 cycles after the last accept.
        clear_mon(); cur_sel = 7'd1; cfg_ready_i = 4'b1011;
        kick(1'b0, 4'hF, 7'd1);
        tick();
        tick();
        chk("t5_v_all", 80'(cfg_v_o), 80'(4'hF));
        tick();
        chk("t5_v_core2", 80'(cfg_v_o), 80'(4'b0100));
        chk("t5_err_early", 80'(err_o), 80'(0));
        repeat (7) tick();
        chk("t5_err_7", 80'(err_o), 80'(0));
        chk("t5_busy_7", 80'(busy_o), 80'(1));
        tick();
        chk("t5_err_8", 80'(err_o), 80'(1));
        chk("t5_v_off", 80'(cfg_v_o), 80'(0));
        chk("t5_busy_off", 80'(busy_o), 80'(0));
        tick();
        chk("t5_err_hold", 80'(err_o), 80'(1));
        chk("t5_no_done", 80'(done_cnt), 80'(0));
        chk("t5_xfer2", 80'(xfers[2]), 80'(0));
        chk("t5_xfer0", 80'(xfers[0]), 80'(1));

        // Empty mask from ERROR: immediate done, error cleared, no ROM reads.
        clear_mon();
        kick(1'b0, 4'h0, 7'd4);
        chk("t6_err_clr", 80'(err_o), 80'(0));
        chk("t6_done", 80'(done_o), 80'(1));
        chk("t6_busy", 80'(busy_o), 80'(0));
        tick();
        chk("t6_done_off", 80'(done_o), 80'(0));
        chk("t6_rom_reads", 80'(rom_reads), 80'(0));

        // Reset in the middle of SEND.
        cfg_ready_i = 4'h0;
        kick(1'b0, 4'hF, 7'd2);
        tick();
        tick();
        chk("t7_send_v", 80'(cfg_v_o), 80'(4'hF));
        reset_i = 1'b1;
        tick();
        chk("t7_ctrl_zero", 80'({cfg_v_o, busy_o, rom_v_o, rom_addr_o, done_o, err_o}), 80'(0));
        chk("t7_bus_zero", {cfg_addr_o, cfg_data_o}, 80'(0));
        reset_i = 1'b0;
        tick();
        chk("t7_idle", 80'(busy_o), 80'(0));
        cfg_ready_i = 4'hF;
        kick(1'b0, 4'hF, 7'd2);
        chk("t7_restart_v", 80'(rom_v_o), 80'(1));
        chk("t7_restart_addr", 80'(rom_addr_o), 80'(11'h020));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
